rvm_axi4_sram_slave: RTL and testbench
======================================

Name: rvm_axi4_sram_slave

Overview:
- AXI4 slave (responder) fronting a single-port SRAM. It is the memory-side counterpart of the core's AXI4 master bridge, letting the core's bus reach on-chip memory in system tests and FPGA builds.
- One transaction in flight at a time. Supports FIXED and INCR bursts of 32-bit beats.
- SRAM has a fixed 1-cycle read latency.

Parameters:
- MEM_BASE, 32'h0000_0000, byte base address of the mapped window.
- MEM_SIZE, 32'h0001_0000, window size in bytes; power of two, at least 4.
- SRAM_AW, 14, SRAM word-address width; log2(MEM_SIZE/4).

Ports:
- ACLK in 1: clock.
- ARESETn in 1: reset, synchronous, active-low.
- AWID in 1: write ID.
- AWADDR in 32: write address.
- AWLEN in 8: write burst length minus 1.
- AWSIZE in 3: write beat size.
- AWBURST in 2: write burst type.
- AWVALID in 1 / AWREADY out 1: write address handshake.
- WDATA in 32, WSTRB in 4, WLAST in 1: write data beat.
- WVALID in 1 / WREADY out 1: write data handshake.
- BID out 1, BRESP out 2, BUSER out 1: write response.
- BVALID out 1 / BREADY in 1: write response handshake.
- ARID in 1, ARADDR in 32, ARLEN in 8, ARSIZE in 3, ARBURST in 2: read address.
- ARVALID in 1 / ARREADY out 1: read address handshake.
- RID out 1, RDATA out 32, RRESP out 2, RLAST out 1, RUSER out 1: read data beat.
- RVALID out 1 / RREADY in 1: read data handshake.
- sram_addr out SRAM_AW: SRAM word address, (addr-MEM_BASE)>>2.
- sram_wdata out 32: SRAM write data.
- sram_rdata in 32: SRAM read data, valid the cycle after a read enable.
- sram_c_en out 1: SRAM chip enable.
- sram_w_en out 1: SRAM write enable.
- sram_b_en out 4: SRAM byte enables.

Behaviour:
- Reset (ARESETn=0 at a rising ACLK edge):
  - State=IDLE.
  - All READY/VALID outputs 0.
  - BRESP=0, RRESP=0, RDATA=0, RLAST=0, BID=0, RID=0.
  - sram_c_en=0, sram_w_en=0, sram_b_en=0.
  - Arbitration priority=read.
- Reset mid-burst abandons the burst at that edge. No response is issued and no further SRAM access occurs.
- BUSER and RUSER are tied to 0.
- States: IDLE, WR_DATA, WR_RESP, RD_REQ, RD_DATA.
- IDLE:
  - AWREADY and ARREADY are combinational: only the selected channel's READY is asserted.
  - Only AWVALID: accept the write.
  - Only ARVALID: accept the read.
  - Both valid: serve the prioritized type. Priority then flips to the other type (round-robin).
  - On accept, latch ID, address, LEN, SIZE, BURST. Clear beat counter and sticky error.
  - Next state is WR_DATA or RD_REQ.
- Burst legality:
  - SIZE!=3'b010 or BURST not in {FIXED=00, INCR=01} makes the whole burst SLVERR (2'b10).
  - An illegal burst performs no SRAM access but is otherwise handshaked normally.
- Beat address:
  - FIXED: the latched address.
  - INCR: previous address + 4, 32-bit wrap-around, no 4KB check.
  - Low 2 bits are ignored for the SRAM index.
- A beat whose address falls outside [MEM_BASE, MEM_BASE+MEM_SIZE) gets DECERR (2'b11) and no SRAM access.
- WR_DATA:
  - WREADY=1.
  - On WVALID&&WREADY for a legal, in-range beat: sram_c_en=1, sram_w_en=1, sram_b_en=WSTRB, sram_wdata=WDATA. These are combinational in the same cycle.
  - Per-beat code: OKAY/SLVERR/DECERR. The sticky code is the maximum value seen.
  - WLAST asserted when beat!=LEN, or deasserted when beat==LEN: sticky SLVERR. Length is still governed by LEN.
  - After beat LEN: WR_RESP.
- WR_RESP:
  - BVALID=1, BRESP=sticky code, BID=latched AWID.
  - Held stable until BREADY, then IDLE.
- RD_REQ:
  - For a legal, in-range beat: sram_c_en=1, sram_w_en=0.
  - Next state is RD_DATA.
- RD_DATA:
  - Entry cycle: RDATA is registered from sram_rdata, or 0 for an error beat. RRESP is set to the beat code.
  - RVALID=1, RLAST=(beat==LEN), RID=latched ARID.
  - All R outputs are stable while RVALID && !RREADY.
  - On RREADY, a non-last beat increments the counter and returns to RD_REQ. The last beat returns to IDLE.
- Latency and throughput:
  - First RVALID comes 2 cycles after the AR handshake. Throughput is 1 read beat per 2 cycles, 1 write beat per cycle.
  - BVALID comes 1 cycle after the last W handshake.
- Beat counter is 8 bits. LEN=255 gives 256 beats; no overflow.

Test Plan:
- Write: AW addr=0x10, LEN=0, INCR, SIZE=2; W data=0xDEADBEEF, strb=0xF, last=1.
  - Required: sram_addr=4, w_en=1, b_en=0xF, BRESP=OKAY.
  - Then read addr=0x10 returns RDATA=0xDEADBEEF, RLAST=1, RRESP=OKAY.
- INCR read: addr=0x20, LEN=3. RREADY low for 3 cycles on beat 1.
  - Required: sram_addr 8,9,10,11 in order.
  - RDATA held during stall; RLAST only on 4th beat.
- Simultaneous AWVALID and ARVALID after reset:
  - Read served first, then the write.
  - A second simultaneous pair: write first.
- Read at MEM_BASE+MEM_SIZE-4, LEN=1, INCR:
  - Required: beat0 OKAY, beat1 DECERR with RDATA=0.
  - Only one sram_c_en pulse.
- Write with AWSIZE=1:
  - No sram_c_en pulses.
  - BRESP=SLVERR.
- Write LEN=3 with WLAST on beat 1:
  - Required: four beats accepted, BRESP=SLVERR.
- ARESETn=0 during RD_DATA:
  - Next cycle RVALID=0, ARREADY=0.
  - With ARVALID=1 after release, the new read is accepted.

Source files
------------

// File: rtl/rvm_axi4_sram_slave.sv
// AXI4 slave in front of a single-port SRAM with 1-cycle read latency.
// One transaction at a time, FIXED/INCR bursts of 32-bit beats, read/write round-robin arbitration.
module rvm_axi4_sram_slave #(
    parameter logic [31:0] MEM_BASE = 32'h0000_0000,
    parameter logic [31:0] MEM_SIZE = 32'h0001_0000,
    parameter int          SRAM_AW  = 14
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    input  logic               AWID,
    input  logic [31:0]        AWADDR,
    input  logic [7:0]         AWLEN,
    input  logic [2:0]         AWSIZE,
    input  logic [1:0]         AWBURST,
    input  logic               AWVALID,
    output logic               AWREADY,
    input  logic [31:0]        WDATA,
    input  logic [3:0]         WSTRB,
    input  logic               WLAST,
    input  logic               WVALID,
    output logic               WREADY,
    output logic               BID,
    output logic [1:0]         BRESP,
    output logic               BUSER,
    output logic               BVALID,
    input  logic               BREADY,
    input  logic               ARID,
    input  logic [31:0]        ARADDR,
    input  logic [7:0]         ARLEN,
    input  logic [2:0]         ARSIZE,
    input  logic [1:0]         ARBURST,
    input  logic               ARVALID,
    output logic               ARREADY,
    output logic               RID,
    output logic [31:0]        RDATA,
    output logic [1:0]         RRESP,
    output logic               RLAST,
    output logic               RUSER,
    output logic               RVALID,
    input  logic               RREADY,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata,
    output logic               sram_c_en,
    output logic               sram_w_en,
    output logic [3:0]         sram_b_en
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_REQ, RD_DATA} state_t;

    typedef struct packed {
        logic        id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic        fixed;
        logic        bad;
    } txn_t;

    state_t      state;
    txn_t        txn;
    logic [7:0]  beat;
    logic [1:0]  sticky;
    logic        prio_rd;
    logic        rd_ok;
    logic        rd_first;
    logic [31:0] rdata_q;

    logic [31:0] offs;
    logic [31:0] next_addr;
    logic        in_range;
    logic        beat_ok;
    logic        last_beat;
    logic [1:0]  beat_code;
    logic [1:0]  w_code;
    logic        aw_sel;
    logic        ar_sel;
    logic        w_hs;
    logic        wr_acc;
    logic        rd_acc;

    function automatic logic [1:0] max2(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Unsigned offset compare covers both window edges, including addresses below MEM_BASE.
    assign offs      = txn.addr - MEM_BASE;
    assign in_range  = offs < MEM_SIZE;
    assign beat_ok   = !txn.bad && in_range;
    assign last_beat = (beat == txn.len);
    assign next_addr = txn.fixed ? txn.addr : txn.addr + 32'd4;
    assign beat_code = txn.bad ? RESP_SLVERR : (!in_range ? RESP_DECERR : RESP_OKAY);
    assign w_code    = max2(beat_code, (WLAST != last_beat) ? RESP_SLVERR : RESP_OKAY);

    assign aw_sel  = AWVALID && (!ARVALID || !prio_rd);
    assign ar_sel  = ARVALID && (!AWVALID || prio_rd);
    assign AWREADY = ARESETn && (state == IDLE) && aw_sel;
    assign ARREADY = ARESETn && (state == IDLE) && ar_sel;
    assign WREADY  = ARESETn && (state == WR_DATA);
    assign w_hs    = WVALID && WREADY;

    assign wr_acc     = w_hs && beat_ok;
    assign rd_acc     = ARESETn && (state == RD_REQ) && beat_ok;
    assign sram_addr  = offs[SRAM_AW+1:2];
    assign sram_wdata = WDATA;
    assign sram_c_en  = wr_acc || rd_acc;
    assign sram_w_en  = wr_acc;
    assign sram_b_en  = wr_acc ? WSTRB : 4'h0;

    // SRAM data is only present in the first RD_DATA cycle; it is captured to hold through stalls.
    assign RDATA = rd_first ? (rd_ok ? sram_rdata : 32'h0) : rdata_q;
    assign BUSER = 1'b0;
    assign RUSER = 1'b0;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state    <= IDLE;
            txn      <= '0;
            beat     <= 8'd0;
            sticky   <= RESP_OKAY;
            prio_rd  <= 1'b1;
            rd_ok    <= 1'b0;
            rd_first <= 1'b0;
            rdata_q  <= 32'h0;
            BVALID   <= 1'b0;
            BRESP    <= RESP_OKAY;
            BID      <= 1'b0;
            RVALID   <= 1'b0;
            RRESP    <= RESP_OKAY;
            RLAST    <= 1'b0;
            RID      <= 1'b0;
        end else begin
            rd_first <= 1'b0;
            if (rd_first)
                rdata_q <= RDATA;
            case (state)
                IDLE: begin
                    if (AWVALID && ARVALID)
                        prio_rd <= !prio_rd;
                    if (aw_sel) begin
                        txn.id    <= AWID;
                        txn.addr  <= AWADDR;
                        txn.len   <= AWLEN;
                        txn.fixed <= (AWBURST == 2'b00);
                        txn.bad   <= (AWSIZE != 3'b010) || AWBURST[1];
                        beat      <= 8'd0;
                        sticky    <= RESP_OKAY;
                        state     <= WR_DATA;
                    end else if (ar_sel) begin
                        txn.id    <= ARID;
                        txn.addr  <= ARADDR;
                        txn.len   <= ARLEN;
                        txn.fixed <= (ARBURST == 2'b00);
                        txn.bad   <= (ARSIZE != 3'b010) || ARBURST[1];
                        beat      <= 8'd0;
                        sticky    <= RESP_OKAY;
                        state     <= RD_REQ;
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        if (last_beat) begin
                            BRESP  <= max2(sticky, w_code);
                            BID    <= txn.id;
                            BVALID <= 1'b1;
                            state  <= WR_RESP;
                        end else begin
                            sticky   <= max2(sticky, w_code);
                            beat     <= beat + 8'd1;
                            txn.addr <= next_addr;
                        end
                    end
                end
                WR_RESP: begin
                    if (BREADY) begin
                        BVALID <= 1'b0;
                        state  <= IDLE;
                    end
                end
                RD_REQ: begin
                    RVALID   <= 1'b1;
                    RLAST    <= last_beat;
                    RID      <= txn.id;
                    RRESP    <= beat_code;
                    rd_ok    <= beat_ok;
                    rd_first <= 1'b1;
                    state    <= RD_DATA;
                end
                RD_DATA: begin
                    if (RREADY) begin
                        RVALID <= 1'b0;
                        RLAST  <= 1'b0;
                        if (last_beat) begin
                            state <= IDLE;
                        end else begin
                            beat     <= beat + 8'd1;
                            txn.addr <= next_addr;
                            state    <= RD_REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rvm_axi4_sram_slave.sv
// Directed bench for rvm_axi4_sram_slave: vector table of single-beat transfers plus
// hand sequences for bursts, stalls, arbitration, window edge, WLAST errors and reset.
module tb_rvm_axi4_sram_slave;

    logic        clk = 1'b0;
    logic        ARESETn;
    logic        AWID, AWVALID, AWREADY;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST, WVALID, WREADY;
    logic        BID, BUSER, BVALID, BREADY;
    logic [1:0]  BRESP;
    logic        ARID, ARVALID, ARREADY;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        RID, RLAST, RUSER, RVALID, RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic [13:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;
    logic        sram_c_en, sram_w_en;
    logic [3:0]  sram_b_en;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rvm_axi4_sram_slave dut (
        .ACLK(clk), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BUSER(BUSER), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RUSER(RUSER),
        .RVALID(RVALID), .RREADY(RREADY),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_c_en(sram_c_en), .sram_w_en(sram_w_en), .sram_b_en(sram_b_en)
    );

    // SRAM model with 1-cycle read latency, plus an access log
    logic [31:0] mem [0:16383];
    logic        mem_clr;
    int          acc_addr[$];
    int          acc_we[$];
    int          acc_ben[$];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16384; i++) mem[i] <= 32'h0;
        end else if (sram_c_en) begin
            acc_addr.push_back(int'(sram_addr));
            acc_we.push_back(int'(sram_w_en));
            acc_ben.push_back(int'(sram_b_en));
            if (sram_w_en) begin
                for (int b = 0; b < 4; b++)
                    if (sram_b_en[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    logic [31:0] r_data [0:255];
    logic [1:0]  r_resp [0:255];
    logic        r_last [0:255];
    logic        r_id   [0:255];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout act=no-handshake exp=handshake", name);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_log;
        acc_addr.delete();
        acc_we.delete();
        acc_ben.delete();
    endtask

    task automatic aw_send(input logic id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        AWID = id; AWADDR = a; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        #1;
        n = 0;
        while (!AWREADY && n < 50) begin tick; n++; end
        if (!AWREADY) tmo("aw");
        tick;
        AWVALID = 1'b0;
    endtask

    task automatic ar_send(input logic id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        ARID = id; ARADDR = a; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        #1;
        n = 0;
        while (!ARREADY && n < 50) begin tick; n++; end
        if (!ARREADY) tmo("ar");
        tick;
        ARVALID = 1'b0;
    endtask

    task automatic w_send(input int len, input logic [31:0] d0, input logic [3:0] strb,
                          input int wl, output int nb);
        int n;
        nb = 0;
        for (int i = 0; i <= len; i++) begin
            WDATA  = d0 + i;
            WSTRB  = strb;
            WLAST  = (wl < 0) ? (i == len) : (i == wl);
            WVALID = 1'b1;
            #1;
            n = 0;
            while (!WREADY && n < 50) begin tick; n++; end
            if (!WREADY) tmo("w");
            else nb++;
            tick;
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
    endtask

    // BVALID is expected on the very cycle after the last W handshake and must hold without BREADY
    task automatic b_get(output logic [1:0] resp, output logic id);
        chk("b_latency", BVALID, 1'b1);
        resp = BRESP;
        id   = BID;
        tick;
        chk("b_hold_valid", BVALID, 1'b1);
        chk("b_hold_resp", BRESP, resp);
        BREADY = 1'b1;
        tick;
        BREADY = 1'b0;
        chk("b_drop", BVALID, 1'b0);
    endtask

    task automatic r_get(input int len, input int stall_beat, input int stall_n, output int lat);
        int n;
        lat = -1;
        for (int b = 0; b <= len; b++) begin
            n = 0;
            while (!RVALID && n < 50) begin tick; n++; end
            if (!RVALID) begin
                tmo("r");
                return;
            end
            if (b == 0) lat = n;
            r_data[b] = RDATA;
            r_resp[b] = RRESP;
            r_last[b] = RLAST;
            r_id[b]   = RID;
            if (b == stall_beat) begin
                for (int s = 0; s < stall_n; s++) begin
                    tick;
                    chk("r_stall_valid", RVALID, 1'b1);
                    chk("r_stall_data", RDATA, r_data[b]);
                    chk("r_stall_last", RLAST, r_last[b]);
                end
            end
            RREADY = 1'b1;
            tick;
            RREADY = 1'b0;
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          nacc;
        int          sidx;
    } vec_t;

    vec_t vt [12];

    initial begin
        logic [1:0] resp;
        logic       id;
        int         nb, lat;

        vt[0]  = '{1'b1, 32'h0000_0010, 3'd2, 2'd1, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0,         1, 4};
        vt[1]  = '{1'b0, 32'h0000_0010, 3'd2, 2'd1, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF, 1, 4};
        vt[2]  = '{1'b1, 32'h0000_0014, 3'd2, 2'd0, 32'h1122_3344, 4'h5, 2'b00, 32'h0,         1, 5};
        vt[3]  = '{1'b0, 32'h0000_0014, 3'd2, 2'd1, 32'h0,         4'h0, 2'b00, 32'h0022_0044, 1, 5};
        vt[4]  = '{1'b1, 32'h0001_0000, 3'd2, 2'd1, 32'hAAAA_AAAA, 4'hF, 2'b11, 32'h0,         0, 0};
        vt[5]  = '{1'b0, 32'h0001_0000, 3'd2, 2'd1, 32'h0,         4'h0, 2'b11, 32'h0,         0, 0};
        vt[6]  = '{1'b1, 32'h0000_0018, 3'd2, 2'd2, 32'h5555_5555, 4'hF, 2'b10, 32'h0,         0, 0};
        vt[7]  = '{1'b0, 32'h0000_0010, 3'd1, 2'd1, 32'h0,         4'h0, 2'b10, 32'h0,         0, 0};
        vt[8]  = '{1'b1, 32'h0000_001C, 3'd1, 2'd1, 32'h7777_7777, 4'hF, 2'b10, 32'h0,         0, 0};
        vt[9]  = '{1'b0, 32'h0000_001C, 3'd2, 2'd1, 32'h0,         4'h0, 2'b00, 32'h0,         1, 7};
        vt[10] = '{1'b0, 32'h0000_0013, 3'd2, 2'd1, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF, 1, 4};
        vt[11] = '{1'b0, 32'hFFFF_FFF0, 3'd2, 2'd1, 32'h0,         4'h0, 2'b11, 32'h0,         0, 0};

        ARESETn = 1'b0; mem_clr = 1'b1;
        AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0; AWVALID = 0;
        WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0; BREADY = 0;
        ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; ARVALID = 0; RREADY = 0;
        tick; tick;
        mem_clr = 1'b0;
        chk("rst_awready", AWREADY, 1'b0);
        chk("rst_arready", ARREADY, 1'b0);
        chk("rst_wready", WREADY, 1'b0);
        chk("rst_bvalid", BVALID, 1'b0);
        chk("rst_rvalid", RVALID, 1'b0);
        chk("rst_rdata", RDATA, 32'h0);
        chk("rst_rlast", RLAST, 1'b0);
        chk("rst_bresp", BRESP, 2'b00);
        chk("rst_rresp", RRESP, 2'b00);
        chk("rst_ids", {BID, RID}, 2'b00);
        chk("rst_user", {BUSER, RUSER}, 2'b00);
        chk("rst_sram_en", {sram_c_en, sram_w_en, sram_b_en}, 6'h0);
        ARESETn = 1'b1;
        tick;

        // contention straight after reset: read wins, then the next contention goes to write
        AWID = 1; AWADDR = 32'h30; AWLEN = 0; AWSIZE = 3'd2; AWBURST = 2'd1; AWVALID = 1'b1;
        ARID = 0; ARADDR = 32'h30; ARLEN = 0; ARSIZE = 3'd2; ARBURST = 2'd1; ARVALID = 1'b1;
        #1;
        chk("arb1_arready", ARREADY, 1'b1);
        chk("arb1_awready", AWREADY, 1'b0);
        ar_send(0, 32'h30, 8'd0, 3'd2, 2'd1);
        chk("arb1_aw_blocked", AWREADY, 1'b0);
        r_get(0, -1, 0, lat);
        chk("arb1_rdata", r_data[0], 32'h0);
        aw_send(1, 32'h30, 8'd0, 3'd2, 2'd1);
        w_send(0, 32'h3333_0000, 4'hF, -1, nb);
        b_get(resp, id);
        chk("arb1_bresp", resp, 2'b00);
        AWVALID = 1'b1; AWADDR = 32'h34;
        ARVALID = 1'b1;
        #1;
        chk("arb2_awready", AWREADY, 1'b1);
        chk("arb2_arready", ARREADY, 1'b0);
        aw_send(1, 32'h34, 8'd0, 3'd2, 2'd1);
        chk("arb2_ar_blocked", ARREADY, 1'b0);
        w_send(0, 32'h4444_0000, 4'hF, -1, nb);
        b_get(resp, id);
        ar_send(0, 32'h30, 8'd0, 3'd2, 2'd1);
        r_get(0, -1, 0, lat);
        chk("arb2_rdata", r_data[0], 32'h3333_0000);

        for (int i = 0; i < 12; i++) begin
            clr_log();
            if (vt[i].wr) begin
                aw_send(i[0], vt[i].addr, 8'd0, vt[i].size, vt[i].burst);
                w_send(0, vt[i].wdata, vt[i].strb, -1, nb);
                b_get(resp, id);
                chk($sformatf("v%0d_bresp", i), resp, vt[i].resp);
                chk($sformatf("v%0d_bid", i), id, i[0]);
                if (vt[i].nacc > 0 && acc_we.size() > 0) begin
                    chk($sformatf("v%0d_wen", i), acc_we[0], 1);
                    chk($sformatf("v%0d_ben", i), acc_ben[0], vt[i].strb);
                end
            end else begin
                ar_send(i[0], vt[i].addr, 8'd0, vt[i].size, vt[i].burst);
                r_get(0, -1, 0, lat);
                chk($sformatf("v%0d_rlat", i), lat, 1);
                chk($sformatf("v%0d_rresp", i), r_resp[0], vt[i].resp);
                chk($sformatf("v%0d_rdata", i), r_data[0], vt[i].rdata);
                chk($sformatf("v%0d_rlast", i), r_last[0], 1'b1);
                chk($sformatf("v%0d_rid", i), r_id[0], i[0]);
            end
            chk($sformatf("v%0d_nacc", i), acc_addr.size(), vt[i].nacc);
            if (vt[i].nacc > 0 && acc_addr.size() > 0)
                chk($sformatf("v%0d_sidx", i), acc_addr[0], vt[i].sidx);
        end

        // INCR write then INCR read with a 3-cycle stall on beat 1
        clr_log();
        aw_send(0, 32'h20, 8'd3, 3'd2, 2'd1);
        w_send(3, 32'hA000_0000, 4'hF, -1, nb);
        b_get(resp, id);
        chk("incw_bresp", resp, 2'b00);
        chk("incw_nacc", acc_addr.size(), 4);
        clr_log();
        ar_send(1, 32'h20, 8'd3, 3'd2, 2'd1);
        r_get(3, 1, 3, lat);
        chk("incr_lat", lat, 1);
        chk("incr_nacc", acc_addr.size(), 4);
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("incr_rdata%0d", b), r_data[b], 32'hA000_0000 + b);
            chk($sformatf("incr_rlast%0d", b), r_last[b], (b == 3));
            chk($sformatf("incr_rresp%0d", b), r_resp[b], 2'b00);
            if (acc_addr.size() > b) begin
                chk($sformatf("incr_sidx%0d", b), acc_addr[b], 8 + b);
                chk($sformatf("incr_wen%0d", b), acc_we[b], 0);
            end
        end

        // read crossing the top of the window
        aw_send(0, 32'h0000_FFFC, 8'd0, 3'd2, 2'd1);
        w_send(0, 32'hCAFE_F00D, 4'hF, -1, nb);
        b_get(resp, id);
        clr_log();
        ar_send(0, 32'h0000_FFFC, 8'd1, 3'd2, 2'd1);
        r_get(1, -1, 0, lat);
        chk("edge_resp0", r_resp[0], 2'b00);
        chk("edge_data0", r_data[0], 32'hCAFE_F00D);
        chk("edge_resp1", r_resp[1], 2'b11);
        chk("edge_data1", r_data[1], 32'h0);
        chk("edge_last1", r_last[1], 1'b1);
        chk("edge_nacc", acc_addr.size(), 1);

        // WLAST on beat 1 of a 4-beat write
        clr_log();
        aw_send(0, 32'h40, 8'd3, 3'd2, 2'd1);
        w_send(3, 32'hB000_0000, 4'hF, 1, nb);
        b_get(resp, id);
        chk("wlast_beats", nb, 4);
        chk("wlast_bresp", resp, 2'b10);
        chk("wlast_nacc", acc_addr.size(), 4);

        // FIXED write: both beats hit one word, last one sticks
        clr_log();
        aw_send(1, 32'h50, 8'd1, 3'd2, 2'd0);
        w_send(1, 32'h0000_1000, 4'hF, -1, nb);
        b_get(resp, id);
        chk("fix_bresp", resp, 2'b00);
        chk("fix_bid", id, 1'b1);
        chk("fix_nacc", acc_addr.size(), 2);
        if (acc_addr.size() == 2) begin
            chk("fix_sidx0", acc_addr[0], 20);
            chk("fix_sidx1", acc_addr[1], 20);
        end
        ar_send(0, 32'h50, 8'd0, 3'd2, 2'd1);
        r_get(0, -1, 0, lat);
        chk("fix_rdata", r_data[0], 32'h0000_1001);

        // reset while a beat is waiting in RD_DATA
        ARID = 0; ARADDR = 32'h10; ARLEN = 8'd1; ARSIZE = 3'd2; ARBURST = 2'd1;
        ar_send(0, 32'h10, 8'd1, 3'd2, 2'd1);
        tick;
        chk("rrst_pre_valid", RVALID, 1'b1);
        clr_log();
        ARESETn = 1'b0;
        ARVALID = 1'b1;
        ARLEN = 8'd0;
        tick;
        chk("rrst_rvalid", RVALID, 1'b0);
        chk("rrst_arready", ARREADY, 1'b0);
        tick;
        ARESETn = 1'b1;
        #1;
        chk("rrst_nacc", acc_addr.size(), 0);
        chk("rrst_arready_rel", ARREADY, 1'b1);
        ar_send(0, 32'h10, 8'd0, 3'd2, 2'd1);
        r_get(0, -1, 0, lat);
        chk("rrst_rdata", r_data[0], 32'hDEAD_BEEF);
        chk("rrst_rresp", r_resp[0], 2'b00);
        chk("rrst_rlast", r_last[0], 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
